mux_4to1: RTL and testbench
===========================

# mux_4to1

Parameterised 4-to-1 multiplexer for the Basys 3 datapath. It selects one of four equal-width data inputs with a 2-bit select. The selected value is driven on a zero-latency combinational output and on a one-cycle registered output, so downstream logic can take whichever timing it needs. It is a leaf block with no handshake and no internal state beyond the output register.

## Interface
Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).

Ports:
- clk  input  1  system clock; y_reg updates on the rising edge.
- rst_n  input  1  reset. Asynchronous, active-low. Clears y_reg.
- a  input  WIDTH  data input, selected when sel = 2'b00.
- b  input  WIDTH  data input, selected when sel = 2'b01.
- c  input  WIDTH  data input, selected when sel = 2'b10.
- d  input  WIDTH  data input, selected when sel = 2'b11.
- sel  input  2  select code.
- y  output  WIDTH  combinational selected value.
- y_reg  output  WIDTH  registered copy of y.

## Operation
- Select mapping is fixed:
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- y is a pure function of a, b, c, d and sel. It does not depend on clk or rst_n.
- All WIDTH bits come from the same selected input. There is no per-bit selection.
- sel containing X or Z (simulation only) drives y to all-zero, not X. Synthesis treats this as don't-care.
- y_reg captures y on each rising clk edge while rst_n = 1.
- There is no enable. y_reg reloads every cycle.

## Timing
- y: zero cycles of latency. Any input change propagates within the same delta or combinational settle time.
- y_reg: one cycle of latency. The value present on y before rising edge N appears on y_reg after edge N.
- Reset assertion (rst_n falls): y_reg goes to 0 immediately, with no clock edge needed. y is unaffected.
- While rst_n = 0: y_reg holds 0 across clock edges. y continues to track its inputs.
- Reset release: the first rising edge with rst_n = 1 loads the current y. rst_n is released synchronously to clk by the top level.
- sel and data changing together before an edge: y_reg takes the new combination, with no mixing of old and new values.
- Reset asserted mid-stream: the registered value is lost. The first post-reset edge reloads it.

## Structure
- Shared package mux_pkg:
  - constants SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11
  - typedef sel_t, a 2-bit logic vector
- Sub-module mux_4to1_comb: the combinational selector only. It is parameterised on WIDTH and has ports a, b, c, d, sel and y.
- mux_4to1 instantiates mux_4to1_comb and adds the y_reg flop with asynchronous active-low clear.

## Test plan
- Exhaustive check, WIDTH = 1: step i over 0..63, apply {a,b,c,d,sel} = i (a is the MSB), hold 20 ns each. Required response: y equals the input named by sel.
  - Example: i = 6'b100000 gives sel = 00 and y = 1.
  - Example: i = 6'b000111 gives sel = 11 and y = d = 1.
- Register latency, WIDTH = 8: a = 8'h11, b = 8'h22, c = 8'h33, d = 8'h44, step sel 00, 01, 10, 11 on consecutive cycles. Required: y_reg reads 11, 22, 33, 44, each one cycle behind y.
- Asynchronous reset: with y_reg = 8'h44, pull rst_n low between edges. Required: y_reg = 0 before the next edge, y still 8'h44, and y_reg stays 0 over 3 edges.
- Reset release: raise rst_n with sel = 10. Required: y_reg = 8'h33 after the first rising edge.
- Simultaneous change: change sel from 00 to 11 and d from 8'h44 to 8'hAA in the same cycle. Required: y = 8'hAA immediately and y_reg = 8'hAA after the next edge.
- X select: drive sel = 2'bx1. Required: y = 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-to-1 multiplexer family.
package mux_pkg;

  // 2-bit select code type used on every select port.
  typedef logic [1:0] sel_t;

  // Fixed select mapping: code -> data input.
  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // Legal range of the data width parameter.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/mux_4to1_if.sv
// Bundle of the multiplexer data/select/result signals.
// No handshake: there is no valid/ready pair. The master drives a, b, c, d
// and sel at any time; the slave presents y combinationally and y_reg one
// rising clk edge later. Every cycle carries a value.
interface mux_4to1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_reg;

  // Source of data and select, consumer of both results.
  modport master (
    output a, b, c, d, sel,
    input  y, y_reg
  );

  // The multiplexer itself.
  modport slave (
    input  a, b, c, d, sel,
    output y, y_reg
  );

endinterface

// File: rtl/mux_4to1_comb.sv
// Combinational 4-to-1 selector. All WIDTH bits come from one input.
module mux_4to1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // Select one input; an unknown select falls to the default and yields zero
  // in simulation rather than propagating X.
  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// 4-to-1 multiplexer with a zero-latency output and a one-cycle registered
// copy. The register clears asynchronously on rst_n low.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_reg
);

  logic [WIDTH-1:0] y_sel;
  logic [WIDTH-1:0] y_reg_d;
  logic [WIDTH-1:0] y_reg_q;

  mux_4to1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .y   (y_sel)
  );

  // No enable: the register reloads the selected value every cycle.
  always_comb begin
    y_reg_d = y_sel;
  end

  // Output register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg_q <= '0;
    end else begin
      y_reg_q <= y_reg_d;
    end
  end

  assign y     = y_sel;
  assign y_reg = y_reg_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1: one WIDTH=1 instance for the exhaustive sweep and one
// WIDTH=8 instance for register timing, reset and randomized traffic.
module tb_mux_4to1;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  mux_4to1_if #(.WIDTH(1)) if1 ();
  mux_4to1_if #(.WIDTH(8)) if8 ();

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (if1.a),
    .b     (if1.b),
    .c     (if1.c),
    .d     (if1.d),
    .sel   (if1.sel),
    .y     (if1.y),
    .y_reg (if1.y_reg)
  );

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (if8.a),
    .b     (if8.b),
    .c     (if8.c),
    .d     (if8.d),
    .sel   (if8.sel),
    .y     (if8.y),
    .y_reg (if8.y_reg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: list the four inputs in select order and index it.
  function automatic logic [7:0] ref_sel(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d,
                                         input logic [1:0] sel);
    logic [7:0] vals[4];
    vals[0] = a;
    vals[1] = b;
    vals[2] = c;
    vals[3] = d;
    if ($isunknown(sel)) return 8'h00;
    return vals[sel];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [1:0] sel);
    if8.a   = a;
    if8.b   = b;
    if8.c   = c;
    if8.d   = d;
    if8.sel = sel;
  endtask

  task automatic drive1(input logic [5:0] v);
    {if1.a, if1.b, if1.c, if1.d, if1.sel} = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp8;
    logic [7:0] ra, rb, rc, rd;
    logic [1:0] rs;
    logic       exp1;

    rst_n = 1'b0;
    drive1(6'd0);
    drive8(8'h0, 8'h0, 8'h0, 8'h0, 2'b00);
    if1.sel = 2'b00;

    // Reset state, with non-zero y to show the register is held clear.
    @(negedge clk);
    drive8(8'h5A, 8'h00, 8'h00, 8'h00, 2'b00);
    drive1(6'b100000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_y_reg8", 64'(if8.y_reg), 64'h0);
    check("reset_y_reg1", 64'(if1.y_reg), 64'h0);
    check("reset_y8_tracks", 64'(if8.y), 64'h5A);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive WIDTH=1 sweep: {a,b,c,d,sel} = i, a is bit 5.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      @(negedge clk);
      drive1(v);
      exp1 = v[5 - int'(v[1:0])];
      #1;
      check($sformatf("exh_y_%0d", i), 64'(if1.y), 64'(exp1));
      @(posedge clk);
      #1;
      check($sformatf("exh_yreg_%0d", i), 64'(if1.y_reg), 64'(exp1));
    end

    // Register latency on WIDTH=8.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      drive8(8'h11, 8'h22, 8'h33, 8'h44, 2'(s));
      exp8 = 8'(8'h11 * (s + 1));
      #1;
      check($sformatf("lat_y_%0d", s), 64'(if8.y), 64'(exp8));
      check($sformatf("lat_yreg_old_%0d", s), 64'(if8.y_reg),
            (s == 0) ? 64'h5A : 64'(8'(8'h11 * s)));
      @(posedge clk);
      #1;
      check($sformatf("lat_yreg_%0d", s), 64'(if8.y_reg), 64'(exp8));
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_yreg_now", 64'(if8.y_reg), 64'h0);
    check("arst_y_keeps", 64'(if8.y), 64'h44);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("arst_hold_%0d", k), 64'(if8.y_reg), 64'h0);
    end

    // Release with sel = 10.
    @(negedge clk);
    if8.sel = 2'b10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_yreg", 64'(if8.y_reg), 64'h33);

    // Simultaneous sel and data change.
    @(negedge clk);
    if8.sel = 2'b00;
    @(posedge clk);
    #1;
    check("simul_pre", 64'(if8.y_reg), 64'h11);
    @(negedge clk);
    if8.sel = 2'b11;
    if8.d   = 8'hAA;
    #1;
    check("simul_y", 64'(if8.y), 64'hAA);
    @(posedge clk);
    #1;
    check("simul_yreg", 64'(if8.y_reg), 64'hAA);

    // Randomized traffic with occasional mid-cycle reset pulses.
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rd = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      drive8(ra, rb, rc, rd, rs);
      exp8 = ref_sel(ra, rb, rc, rd, rs);
      #1;
      check("rand_y", 64'(if8.y), 64'(exp8));
      if (rst_n && $urandom_range(0, 15) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rand_arst", 64'(if8.y_reg), 64'h0);
      end
      @(posedge clk);
      exp_q.push_back(rst_n ? exp8 : 8'h00);
      #1;
      if (exp_q.size() == 0) begin
        check("rand_q_empty", 64'h1, 64'h0);
      end else begin
        check("rand_yreg", 64'(if8.y_reg), 64'(exp_q.pop_front()));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Unknown select drives zero (b and d zero so a two-state run agrees).
    @(negedge clk);
    drive8(8'h5A, 8'h00, 8'hC3, 8'h00, 2'bx1);
    #1;
    check("x_sel_y", 64'(if8.y), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
